// File: rtl/toggle_event_decoder_pkg.sv
// Shared types and elaboration helpers for the toggle event decoder.
package toggle_event_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StReport  = 2'd2
    } state_e;

    // Wide enough to hold TMO_CYC-1 with a spare bit.
    function automatic int unsigned timer_width(input int unsigned tmo_cyc);
        return $clog2(tmo_cyc) + 1;
    endfunction

    function automatic bit params_legal(input int unsigned sync_stages,
                                        input int unsigned cnt_w,
                                        input int unsigned batch,
                                        input int unsigned tmo_cyc);
        if (sync_stages < 1 || sync_stages > 4) return 1'b0;
        if (cnt_w < 1 || cnt_w > 31) return 1'b0;
        if (batch < 1 || batch > ((32'd1 << cnt_w) - 32'd1)) return 1'b0;
        if (tmo_cyc < 1) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/toggle_event_decoder_sync.sv
// Toggle-line synchroniser with history flop, post-reset arming mask and a
// registered one-cycle pulse per level transition.
module toggle_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic pulse
);

    // Sync chain plus history must all hold the live level before edges count.
    localparam int unsigned ArmCycles = SYNC_STAGES + 1;
    localparam int unsigned ArmW      = $clog2(ArmCycles + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q;
    logic                   pulse_q;
    logic [ArmW-1:0]        arm_cnt_q;
    logic                   armed;

    assign armed = (arm_cnt_q == ArmW'(ArmCycles));

    // Shift the new sample into stage 0.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = tog_in;
    end

    // Synchroniser, history, arming counter and registered edge strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            pulse_q   <= 1'b0;
            arm_cnt_q <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= armed & (sync_q[SYNC_STAGES-1] ^ hist_q);
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns toggle-line transitions into pulses, batches them and reports each
// batch count over a valid/ready interface.
module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned BATCH       = 16,
    parameter int unsigned TMO_CYC     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             pulse,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             ovf
);

    localparam int unsigned     TmrW    = timer_width(TMO_CYC);
    localparam logic [CNT_W-1:0] AccMax  = '1;
    localparam logic [CNT_W-1:0] BatchV  = CNT_W'(BATCH);
    localparam logic [TmrW-1:0]  TmrLast = TmrW'(TMO_CYC - 1);

    if (!params_legal(SYNC_STAGES, CNT_W, BATCH, TMO_CYC)) begin : g_bad_params
        $error("toggle_event_decoder: illegal parameter combination");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ev;

    toggle_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .tog_in(tog_in),
        .pulse (ev)
    );

    // Batch FSM next state: saturating accumulate, idle timeout, handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        timer_d = timer_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        acc_inc = acc_q;
        if (ev) begin
            if (acc_q == AccMax) begin
                ovf_d = 1'b1;
            end else begin
                acc_inc = acc_q + 1'b1;
            end
        end
        unique case (state_q)
            StIdle: begin
                if (ev) begin
                    state_d = StCollect;
                    acc_d   = CNT_W'(1);
                    timer_d = '0;
                end
            end
            StCollect: begin
                acc_d   = acc_inc;
                timer_d = ev ? '0 : timer_q + 1'b1;
                // An event in the timeout cycle restarts the timer instead.
                if (acc_inc >= BatchV || (!ev && timer_q == TmrLast)) begin
                    state_d = StReport;
                    data_d  = acc_inc;
                    acc_d   = '0;
                    timer_d = '0;
                    valid_d = 1'b1;
                end
            end
            StReport: begin
                acc_d = acc_inc;
                if (cnt_ready) begin
                    valid_d = 1'b0;
                    timer_d = '0;
                    state_d = (acc_inc != '0) ? StCollect : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
                timer_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Batch FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse     = ev;
    assign cnt_valid = valid_q;
    assign cnt_data  = data_q;
    assign ovf       = ovf_q;

endmodule
